// File: rtl/char_select_ctrl_if.sv
// Character-select bus: raw buttons and the frame pulse go in, and the glyph
// address and status flags come out. clk9MHz and reset stay plain ports.
interface char_select_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              button1;
    logic              button0;
    logic              frameStart;
    logic [ADDR_W-1:0] characterAddress;
    logic              pending;
    logic              addrUpdated;

    // Display side: drives the buttons and frameStart, observes the address.
    modport master (
        output button1, button0, frameStart,
        input  characterAddress, pending, addrUpdated
    );

    // Controller side.
    modport slave (
        input  button1, button0, frameStart,
        output characterAddress, pending, addrUpdated
    );
endinterface

// File: rtl/char_select_ctrl.sv
// char_select_ctrl: a frame-synchronous glyph-select controller on clk9MHz.
// Each raw button is synchronised and debounced, and each press becomes an
// up or down step request. At most one step is held pending, and it is
// committed to characterAddress only on frameStart.
// Optional macro AUTO_REPEAT_EN adds held-button auto-repeat through the
// HOLD_DELAY and REPEAT states. Without it, each press gives exactly one step.
module char_select_ctrl #(
    parameter int NUM_CHARS       = 13,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 90000,
    parameter int REPEAT_DELAY    = 4500000,
    parameter int REPEAT_PERIOD   = 1500000
) (
    input logic               clk9MHz,
    input logic               reset,
    char_select_ctrl_if.slave bus
);

    // An unusable parameter set shows up as a g_illegal_params scope in the hierarchy.
    if (NUM_CHARS < 1 || NUM_CHARS > (1 << ADDR_W) || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_illegal_params
    end

    localparam int                DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_CHARS - 1);

    // Index 1 = button1 (step up), index 0 = button0 (step down); all active-low.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      req;

    logic              new_up;
    logic              new_dn;
    logic              has_new;
    logic              pend_up;
    logic              commit_d;
    logic [ADDR_W-1:0] addr;
    logic              pend;
    logic              updated;

    // Gather the raw buttons and classify this cycle's request; simultaneous up+down is discarded.
    always_comb begin
        raw     = {bus.button1, bus.button0};
        new_up  = req[1] & ~req[0];
        new_dn  = req[0] & ~req[1];
        has_new = new_up | new_dn;
    end

    assign bus.characterAddress = addr;
    assign bus.pending          = pend;
    assign bus.addrUpdated      = updated;

    // Two-flop synchroniser followed by a stable-count debouncer for each button.
    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD_DELAY, REPEAT} btn_state_t;

    localparam int              TM_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              TM_W    = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;
    localparam logic [TM_W-1:0] RD_LAST = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] RP_LAST = TM_W'(REPEAT_PERIOD - 1);

    btn_state_t      state [2];
    logic [TM_W-1:0] timer [2];

    // Per-button press/auto-repeat FSM with a registered step request.
    // In IDLE, a low debounced level can only mean a fresh 1->0 edge, because
    // every state falls back to IDLE as soon as the level returns high.
    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            req <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                req[i] <= 1'b0;
                if (level[i]) begin
                    state[i] <= IDLE;
                    timer[i] <= '0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            state[i] <= HOLD_DELAY;
                            req[i]   <= 1'b1;
                            timer[i] <= '0;
                        end
                        HOLD_DELAY: begin
                            if (timer[i] == RD_LAST) begin
                                state[i] <= REPEAT;
                                req[i]   <= 1'b1;
                                timer[i] <= '0;
                            end else begin
                                timer[i] <= timer[i] + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (timer[i] == RP_LAST) begin
                                req[i]   <= 1'b1;
                                timer[i] <= '0;
                            end else begin
                                timer[i] <= timer[i] + 1'b1;
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                            timer[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    typedef enum logic {IDLE, HELD} btn_state_t;

    btn_state_t state [2];

    // Per-button press FSM: exactly one registered step request per accepted press.
    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            req <= '0;
            for (int unsigned i = 0; i < 2; i++) state[i] <= IDLE;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                req[i] <= 1'b0;
                if (level[i]) begin
                    state[i] <= IDLE;
                end else if (state[i] == IDLE) begin
                    state[i] <= HELD;
                    req[i]   <= 1'b1;
                end
            end
        end
    end
`endif

    // One-deep pending step, committed modulo NUM_CHARS on frameStart.
    // addrUpdated trails the address change by one cycle.
    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            addr     <= '0;
            pend     <= 1'b0;
            pend_up  <= 1'b0;
            commit_d <= 1'b0;
            updated  <= 1'b0;
        end else begin
            commit_d <= 1'b0;
            updated  <= commit_d;
            if (bus.frameStart && pend) begin
                commit_d <= 1'b1;
                if (pend_up) addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
                else         addr <= (addr == '0) ? ADDR_LAST : addr - 1'b1;
            end
            if (bus.frameStart) begin
                // The old entry commits above, and any new request becomes the sole pending entry.
                pend <= has_new;
                if (has_new) pend_up <= new_up;
            end else if (has_new) begin
                if (!pend) begin
                    pend    <= 1'b1;
                    pend_up <= new_up;
                end else if (pend_up != new_up) begin
                    pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_select_ctrl.sv
// Directed bench for char_select_ctrl using a small configuration
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Expected addresses are queued when a commit is provoked, then popped on each addrUpdated pulse.
module tb_char_select_ctrl;
    localparam int NUM_CHARS = 13;
    localparam int ADDR_W    = 4;

    logic clk9MHz = 1'b0;
    logic reset;
    always #5 clk9MHz = ~clk9MHz;

    char_select_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    char_select_ctrl #(
        .NUM_CHARS      (NUM_CHARS),
        .ADDR_W         (ADDR_W),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk9MHz(clk9MHz),
        .reset  (reset),
        .bus    (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    int model_addr = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk9MHz);
    endtask

    task automatic push_step(input int dir);
        model_addr = (model_addr + dir + NUM_CHARS) % NUM_CHARS;
        exp_q.push_back(model_addr);
    endtask

    task automatic frame_pulse();
        bus.frameStart = 1'b1;
        cycles(1);
        bus.frameStart = 1'b0;
        cycles(4);
    endtask

    // Hold one button low for 'hold' sampled cycles, then release it and let it settle.
    task automatic press(input int btn, input int hold);
        if (btn == 1) bus.button1 = 1'b0;
        else          bus.button0 = 1'b0;
        cycles(hold);
        bus.button1 = 1'b1;
        bus.button0 = 1'b1;
        cycles(10);
    endtask

    // Scoreboard side: every addrUpdated pulse must match the oldest queued address.
    always @(negedge clk9MHz) begin
        if (bus.addrUpdated === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_update", 32'(bus.addrUpdated), 32'd0);
            else                   check("commit_addr", 32'(bus.characterAddress), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int waited;
        reset          = 1'b1;
        bus.button1    = 1'b1;
        bus.button0    = 1'b1;
        bus.frameStart = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        check("reset_addr", 32'(bus.characterAddress), 32'd0);
        check("reset_pending", 32'(bus.pending), 32'd0);
        check("reset_updated", 32'(bus.addrUpdated), 32'd0);

        // A three-sample glitch is shorter than the debounce window.
        bus.button1 = 1'b0;
        cycles(3);
        bus.button1 = 1'b1;
        cycles(12);
        check("glitch_pending", 32'(bus.pending), 32'd0);
        check("glitch_addr", 32'(bus.characterAddress), 32'd0);

        // Clean press: pending rises 7 cycles after the first low sample.
        bus.button1 = 1'b0;
        cycles(7);
        check("pending_early", 32'(bus.pending), 32'd0);
        cycles(1);
        check("pending_latency", 32'(bus.pending), 32'd1);
        cycles(2);
        bus.button1 = 1'b1;
        cycles(10);
        push_step(1);
        frame_pulse();
        check("commit_clears_pending", 32'(bus.pending), 32'd0);

        // Step down 1 -> 0, then wrap 0 -> 12, then wrap 12 -> 0.
        press(0, 9);
        push_step(-1);
        frame_pulse();
        press(0, 9);
        push_step(-1);
        frame_pulse();
        check("wrap_down_addr", 32'(bus.characterAddress), 32'd12);
        press(1, 9);
        push_step(1);
        frame_pulse();
        check("wrap_up_addr", 32'(bus.characterAddress), 32'd0);

        // Opposite directions cancel, so the next frame commits nothing.
        press(1, 9);
        check("pending_before_cancel", 32'(bus.pending), 32'd1);
        press(0, 9);
        check("cancel_pending", 32'(bus.pending), 32'd0);
        frame_pulse();
        check("cancel_addr", 32'(bus.characterAddress), 32'd0);

        // A second request in the same direction is dropped.
        press(1, 9);
        press(1, 9);
        check("same_dir_pending", 32'(bus.pending), 32'd1);
        push_step(1);
        frame_pulse();
        frame_pulse();
        check("same_dir_addr", 32'(bus.characterAddress), 32'd1);

        // frameStart lands on the same cycle as a new down request while up is pending.
        press(1, 9);
        push_step(1);
        bus.button0 = 1'b0;
        cycles(7);
        bus.frameStart = 1'b1;
        cycles(1);
        bus.frameStart = 1'b0;
        check("overlap_pending", 32'(bus.pending), 32'd1);
        cycles(2);
        bus.button0 = 1'b1;
        cycles(10);
        push_step(-1);
        frame_pulse();
        check("overlap_addr", 32'(bus.characterAddress), 32'd1);

        // Hold button1 for 60 cycles with frameStart every cycle.
`ifdef AUTO_REPEAT_EN
        for (int k = 0; k < 6; k++) push_step(1);
`else
        push_step(1);
`endif
        bus.frameStart = 1'b1;
        bus.button1    = 1'b0;
        cycles(60);
        bus.button1 = 1'b1;
        cycles(12);
        bus.frameStart = 1'b0;
        cycles(4);
        check("repeat_outstanding", 32'(exp_q.size()), 32'd0);
        check("repeat_pending", 32'(bus.pending), 32'd0);

        // Walk to address 5, leave an up step pending, and then reset.
        for (int k = 0; k < NUM_CHARS && model_addr != 5; k++) begin
            press(1, 9);
            push_step(1);
            frame_pulse();
        end
        press(1, 9);
        check("pre_reset_addr", 32'(bus.characterAddress), 32'd5);
        check("pre_reset_pending", 32'(bus.pending), 32'd1);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        model_addr = 0;
        check("post_reset_addr", 32'(bus.characterAddress), 32'd0);
        check("post_reset_pending", 32'(bus.pending), 32'd0);
        check("post_reset_updated", 32'(bus.addrUpdated), 32'd0);
        frame_pulse();
        check("no_commit_after_reset", 32'(bus.characterAddress), 32'd0);

        // A button held through reset is accepted once it has been stable low again.
        bus.button1 = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(2);
        reset  = 1'b0;
        waited = 0;
        while (bus.pending !== 1'b1 && waited < 12) begin
            cycles(1);
            waited++;
        end
        check("held_reset_press", 32'(bus.pending), 32'd1);
        bus.button1 = 1'b1;
        cycles(10);
        push_step(1);
        frame_pulse();
        check("held_reset_addr", 32'(bus.characterAddress), 32'd1);

        cycles(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
